// File: rtl/lz_denorm_pkg.sv
// ============================================================================
//  Package     : lz_pkg
//  Description : Shared definitions for the lz_denorm block. Holds the FSM
//                state encoding, the default data width and the helper that
//                sizes the shift-count field from the data width.
//  Optional    : none (LZ_DENORM_STICKY_EN is consumed by lz_denorm and
//                lz_denorm_if, not here)
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package lz_pkg;

  localparam int c_default_width = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Bits needed to hold any count 0..width inclusive, i.e. clog2(width+1).
  // Loop stops at 30 so (1 << i) never reaches the int sign bit.
  function automatic int cw_of(input int width);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < (width + 1)) r = i + 1;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lz_denorm_if.sv
// ============================================================================
//  Interface   : lz_denorm_if
//  Description : Bundles the request/response handshake and data of
//                lz_denorm. The master modport is the producer/consumer that
//                talks to the block; the slave modport is the block itself.
//  Signals     : in_valid/in_ready/mant/cnt    request side
//                out_valid/out_ready/data/norm_err  result side
//                sticky (only with LZ_DENORM_STICKY_EN defined)
//  Optional    : LZ_DENORM_STICKY_EN adds the sticky signal
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface lz_denorm_if
  import lz_pkg::*;
#(
  parameter int WIDTH = c_default_width,
  parameter int CW    = cw_of(WIDTH)
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] mant;
  logic [CW-1:0]    cnt;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] data;
  logic             norm_err;

`ifdef LZ_DENORM_STICKY_EN
  logic             sticky;

  modport master (
    output in_valid, mant, cnt, out_ready,
    input  in_ready, out_valid, data, norm_err, sticky
  );

  modport slave (
    input  in_valid, mant, cnt, out_ready,
    output in_ready, out_valid, data, norm_err, sticky
  );
`else
  modport master (
    output in_valid, mant, cnt, out_ready,
    input  in_ready, out_valid, data, norm_err
  );

  modport slave (
    input  in_valid, mant, cnt, out_ready,
    output in_ready, out_valid, data, norm_err
  );
`endif

endinterface

`default_nettype wire

// File: rtl/lz_denorm.sv
// ============================================================================
//  Module      : lz_denorm
//  Description : Denormalizer. Accepts a normalized mantissa and a count,
//                then shifts the mantissa right one bit per cycle, inserting
//                that many leading zeros (count clamped to WIDTH). Result is
//                held until consumed.
//  Ports       : i_clk, i_rst_n (async, active-low)
//                i_valid/o_ready, i_mant, i_cnt      request handshake
//                o_valid/i_ready, o_data, o_norm_err result handshake
//                o_sticky  OR of shifted-out bits (optional)
//  Optional    : LZ_DENORM_STICKY_EN adds o_sticky and its register
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module lz_denorm
  import lz_pkg::*;
#(
  parameter  int WIDTH = c_default_width,
  localparam int CW    = cw_of(WIDTH)
) (
  input  wire              i_clk,
  input  wire              i_rst_n,
  input  wire              i_valid,
  output logic             o_ready,
  input  wire  [WIDTH-1:0] i_mant,
  input  wire  [CW-1:0]    i_cnt,
  output logic             o_valid,
  input  wire              i_ready,
  output logic [WIDTH-1:0] o_data,
`ifdef LZ_DENORM_STICKY_EN
  output logic             o_sticky,
`endif
  output logic             o_norm_err
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_data;
  logic [CW-1:0]    r_rem;
  logic             r_norm_err;
  logic [CW-1:0]    w_cnt_clamp;

  // Counts beyond WIDTH would shift out everything anyway; clamping keeps
  // latency bounded at WIDTH+1 edges.
  assign w_cnt_clamp = (i_cnt > CW'(WIDTH)) ? CW'(WIDTH) : i_cnt;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (i_valid) w_state_nxt = (w_cnt_clamp == '0) ? DONE : SHIFT;
      SHIFT:   if (r_rem == CW'(1)) w_state_nxt = DONE;
      DONE:    if (i_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_data     <= '0;
      r_rem      <= '0;
      r_norm_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: begin
          if (i_valid) begin
            r_data     <= i_mant;
            r_rem      <= w_cnt_clamp;
            r_norm_err <= ~i_mant[WIDTH-1];
          end
        end
        SHIFT: begin
          r_data <= r_data >> 1;
          r_rem  <= r_rem - CW'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef LZ_DENORM_STICKY_EN
  logic r_sticky;

  // Cleared on accept, then collects every LSB that falls off the register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sticky <= 1'b0;
    end else begin
      case (r_state)
        IDLE:    if (i_valid) r_sticky <= 1'b0;
        SHIFT:   r_sticky <= r_sticky | r_data[0];
        default: ;
      endcase
    end
  end

  assign o_sticky = r_sticky;
`endif

  assign o_ready    = (r_state == IDLE);
  assign o_valid    = (r_state == DONE);
  assign o_data     = r_data;
  assign o_norm_err = r_norm_err;

endmodule

`default_nettype wire

// File: tb/tb_lz_denorm.sv
// ============================================================================
//  Module      : tb_lz_denorm
//  Description : Directed self-checking bench for lz_denorm at WIDTH=8.
//  Optional    : LZ_DENORM_STICKY_EN enables the o_sticky checks
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_lz_denorm;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  lz_denorm_if #(.WIDTH(8)) bus ();

  lz_denorm #(.WIDTH(8)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_valid    (bus.in_valid),
    .o_ready    (bus.in_ready),
    .i_mant     (bus.mant),
    .i_cnt      (bus.cnt),
    .o_valid    (bus.out_valid),
    .i_ready    (bus.out_ready),
    .o_data     (bus.data),
`ifdef LZ_DENORM_STICKY_EN
    .o_sticky   (bus.sticky),
`endif
    .o_norm_err (bus.norm_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_sticky(input string tag, input logic exp);
`ifdef LZ_DENORM_STICKY_EN
    chk(tag, 32'(bus.sticky), 32'(exp));
`endif
  endtask

  // Drive one request and return the number of rising edges (accept edge
  // counted as 1) until o_valid is seen. Bounded at 40 edges.
  task automatic send(input logic [7:0] mant, input logic [3:0] cnt, output int edges);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.mant     = mant;
    bus.cnt      = cnt;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    while (!bus.out_valid && edges < 40) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
  endtask

  task automatic pop(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({tag, "_ovalid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_ready"},  32'(bus.in_ready),  32'd1);
  endtask

  function automatic int lzc8(input logic [7:0] d);
    int  n;
    logic hit;
    n   = 0;
    hit = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (d[i]) hit = 1'b1;
      if (!hit) n++;
    end
    return n;
  endfunction

  initial begin
    int         e;
    logic       seen;
    logic [7:0] m;
    logic [7:0] exp_d;
    total = 0;
    bad   = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.mant      = '0;
    bus.cnt       = '0;
    bus.out_ready = 1'b0;

    // Reset state
    #12;
    chk("rst_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_ovalid", 32'(bus.out_valid), 32'd0);
    chk("rst_data",   32'(bus.data),      32'd0);
    chk("rst_nerr",   32'(bus.norm_err),  32'd0);
    chk_sticky("rst_sticky", 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1011_0000 >> 2
    send(8'hB0, 4'd2, e);
    chk("t1_lat",  32'(e),            32'd3);
    chk("t1_data", 32'(bus.data),     32'h2C);
    chk("t1_nerr", 32'(bus.norm_err), 32'd0);
    chk_sticky("t1_sticky", 1'b0);
    pop("t1_pop");

    // Zero count: valid after the accept edge
    send(8'h83, 4'd0, e);
    chk("t2a_lat",  32'(e),        32'd1);
    chk("t2a_data", 32'(bus.data), 32'h83);
    chk_sticky("t2a_sticky", 1'b0);
    pop("t2a_pop");

    // Count above WIDTH clamps to 8 -> 9 edges, all zeros
    send(8'h83, 4'd9, e);
    chk("t2b_lat",  32'(e),        32'd9);
    chk("t2b_data", 32'(bus.data), 32'h00);
    chk_sticky("t2b_sticky", 1'b1);
    pop("t2b_pop");

    // Backpressure: hold result 5 cycles while new requests are offered
    send(8'hC1, 4'd3, e);
    chk("t3_lat", 32'(e), 32'd4);
    for (int k = 0; k < 5; k++) begin
      bus.in_valid = 1'b1;
      bus.mant     = 8'hFF;
      bus.cnt      = 4'd0;
      @(posedge clk);
      @(negedge clk);
      chk("t3_hold_data",   32'(bus.data),      32'h18);
      chk("t3_hold_ovalid", 32'(bus.out_valid), 32'd1);
      chk("t3_hold_ready",  32'(bus.in_ready),  32'd0);
      chk_sticky("t3_hold_sticky", 1'b1);
    end
    // Release with a request still asserted: must not be accepted that edge
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    chk("t3_rel_ovalid", 32'(bus.out_valid), 32'd0);
    chk("t3_rel_ready",  32'(bus.in_ready),  32'd1);
    @(posedge clk);
    @(negedge clk);
    chk("t3_idle_ovalid", 32'(bus.out_valid), 32'd0);

    // Unnormalized mantissa
    send(8'h55, 4'd1, e);
    chk("t4_lat",  32'(e),            32'd2);
    chk("t4_data", 32'(bus.data),     32'h2A);
    chk("t4_nerr", 32'(bus.norm_err), 32'd1);
    chk_sticky("t4_sticky", 1'b1);
    pop("t4_pop");

    // Reset mid-SHIFT after three shifts (data = 0x10 at that point)
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.mant     = 8'h81;
    bus.cnt      = 4'd6;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_ready",  32'(bus.in_ready),  32'd1);
    chk("t5_ovalid", 32'(bus.out_valid), 32'd0);
    chk("t5_data",   32'(bus.data),      32'd0);
    chk("t5_nerr",   32'(bus.norm_err),  32'd0);
    chk_sticky("t5_sticky", 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    seen  = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    chk("t5_no_valid", 32'(seen), 32'd0);

    // Random normalized mantissas for every count 0..7
    for (int c = 0; c < 8; c++) begin
      for (int k = 0; k < 6; k++) begin
        m     = 8'h80 | 8'($urandom_range(0, 127));
        exp_d = m >> c;
        send(m, 4'(c), e);
        chk("t6_lat",  32'(e),              32'(c + 1));
        chk("t6_data", 32'(bus.data),       32'(exp_d));
        chk("t6_lzc",  32'(lzc8(bus.data)), 32'(c));
        chk("t6_nerr", 32'(bus.norm_err),   32'd0);
        chk_sticky("t6_sticky", (m & ((8'd1 << c) - 8'd1)) != 8'd0);
        pop("t6_pop");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
